// File: rtl/rename_ckpt_file.sv
// rename_ckpt_file: register rename tag/data file with per-register circular branch checkpoints
module rename_ckpt_file #(
  parameter int NREG = 32,
  parameter int NAME_W = 5,
  parameter int DATA_W = 32,
  parameter int TAG_W = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = '1,
  parameter int DEPTH = 4,
  parameter int NWB = 2,
  parameter int NRD = 2,
  localparam int CK_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWB-1:0]        wbEn,
  input  logic [NWB*TAG_W-1:0]  wbTag,
  input  logic [NWB*DATA_W-1:0] wbData,
  input  logic [NRD*NAME_W-1:0] rdName,
  output logic [NRD*DATA_W-1:0] rdData,
  output logic [NRD*TAG_W-1:0]  rdTag,
  input  logic                  renEn,
  input  logic [NAME_W-1:0]     renName,
  input  logic [TAG_W-1:0]      renTag,
  input  logic                  branchDeeper,
  input  logic                  bFreeEn,
  input  logic                  misTaken,
  output logic [CK_W-1:0]       ckptCnt,
  output logic                  ckptFull,
  output logic                  ovfErr
);
  logic [TAG_W-1:0]  tags [NREG][DEPTH];
  logic [DATA_W-1:0] dat  [NREG][DEPTH];
  logic [TAG_W-1:0]  wt   [NREG][DEPTH];
  logic [DATA_W-1:0] wd   [NREG][DEPTH];
  logic [TAG_W-1:0]  nt   [NREG][DEPTH];
  logic [DATA_W-1:0] nd   [NREG][DEPTH];
  logic [CK_W-1:0] head, tail, nhead, ntail, tail_p1;
  logic deeper;
  assign ckptCnt = tail - head;
  assign ckptFull = ckptCnt == CK_W'(DEPTH - 1);
  assign tail_p1 = tail + 1'b1;
  assign deeper = branchDeeper && !ckptFull;
  always_comb begin
    wt = tags;
    wd = dat;
    for (int r = 0; r < NREG; r++)
      for (int s = 0; s < DEPTH; s++)
        for (int k = NWB - 1; k >= 0; k--)
          if (wbEn[k] && wbTag[k*TAG_W +: TAG_W] != TAG_FREE && tags[r][s] == wbTag[k*TAG_W +: TAG_W]) begin
            wt[r][s] = TAG_FREE;
            wd[r][s] = wbData[k*DATA_W +: DATA_W];
          end
  end
  // misprediction only rewinds tail; writebacks above still land in every slot
  always_comb begin
    nt = wt;
    nd = wd;
    nhead = head;
    ntail = tail;
    if (misTaken) ntail = head;
    else begin
      if (renEn && renName != '0) nt[renName][tail] = renTag;
      if (deeper) begin
        ntail = tail_p1;
        for (int r = 0; r < NREG; r++) begin
          nt[r][tail_p1] = nt[r][tail];
          nd[r][tail_p1] = wd[r][tail];
        end
      end
      if (bFreeEn && ckptCnt != '0) nhead = head + 1'b1;
    end
  end
  always_comb begin
    rdData = '0;
    rdTag = '0;
    for (int p = 0; p < NRD; p++) begin
      rdData[p*DATA_W +: DATA_W] = rdName[p*NAME_W +: NAME_W] == '0 ? '0 : wd[rdName[p*NAME_W +: NAME_W]][tail];
      rdTag[p*TAG_W +: TAG_W] = rdName[p*NAME_W +: NAME_W] == '0 ? TAG_FREE : wt[rdName[p*NAME_W +: NAME_W]][tail];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      ovfErr <= 1'b0;
      for (int r = 0; r < NREG; r++)
        for (int s = 0; s < DEPTH; s++) begin
          tags[r][s] <= TAG_FREE;
          dat[r][s] <= '0;
        end
    end else begin
      head <= nhead;
      tail <= ntail;
      ovfErr <= ovfErr | (branchDeeper && ckptFull && !misTaken);
      tags <= nt;
      dat <= nd;
    end
  end
endmodule

// File: tb/tb_rename_ckpt_file.sv
// tb_rename_ckpt_file: scoreboard-driven bench for the rename checkpoint file
module tb_rename_ckpt_file;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] wbEn;
  logic [7:0] wbTag;
  logic [63:0] wbData;
  logic [9:0] rdName;
  logic [63:0] rdData;
  logic [7:0] rdTag;
  logic renEn;
  logic [4:0] renName;
  logic [3:0] renTag;
  logic branchDeeper, bFreeEn, misTaken;
  logic [1:0] ckptCnt;
  logic ckptFull, ovfErr;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [4:0] name; logic [3:0] tag; logic [31:0] data;} rd_t;
  rd_t exp_q[$];

  rename_ckpt_file dut (
    .clk(clk), .rst(rst), .wbEn(wbEn), .wbTag(wbTag), .wbData(wbData),
    .rdName(rdName), .rdData(rdData), .rdTag(rdTag), .renEn(renEn),
    .renName(renName), .renTag(renTag), .branchDeeper(branchDeeper),
    .bFreeEn(bFreeEn), .misTaken(misTaken), .ckptCnt(ckptCnt),
    .ckptFull(ckptFull), .ovfErr(ovfErr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wbEn = '0;
    renEn = 1'b0;
    branchDeeper = 1'b0;
    bFreeEn = 1'b0;
    misTaken = 1'b0;
  endtask

  task automatic expect_rd(input logic [4:0] n, input logic [3:0] t, input logic [31:0] d);
    exp_q.push_back('{n, t, d});
  endtask

  task automatic check_rd(input string lbl);
    rd_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rdName = {e.name, e.name};
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rdTag[p*4 +: 4] !== e.tag || rdData[p*32 +: 32] !== e.data) begin
          errors++;
          $display("FAIL %s x%0d port%0d: got tag %h data %h, want tag %h data %h",
                   lbl, e.name, p, rdTag[p*4 +: 4], rdData[p*32 +: 32], e.tag, e.data);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    checks++;
    if ({ckptCnt, ckptFull, ovfErr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got cnt %0d full %b ovf %b, want 0 0 0", ckptCnt, ckptFull, ovfErr);
    end
    expect_rd(5'd0, 4'hF, 32'h0);
    expect_rd(5'd5, 4'hF, 32'h0);
    expect_rd(5'd31, 4'hF, 32'h0);
    check_rd("reset_read");
  endtask

  task automatic test_wb_forward;
    renEn = 1'b1; renName = 5'd5; renTag = 4'd3;
    step();
    idle();
    expect_rd(5'd5, 4'd3, 32'h0);
    check_rd("renamed_pre_wb");
    wbEn = 2'b01; wbTag = {4'h0, 4'h3}; wbData = {32'h0, 32'hAB};
    expect_rd(5'd5, 4'hF, 32'hAB);
    check_rd("wb_forward");
    step();
    idle();
    expect_rd(5'd5, 4'hF, 32'hAB);
    check_rd("wb_hold");
  endtask

  task automatic test_branch_restore;
    renEn = 1'b1; renName = 5'd7; renTag = 4'd2; branchDeeper = 1'b1;
    step();
    idle();
    checks++;
    if (ckptCnt !== 2'd1) begin
      errors++;
      $display("FAIL deeper_cnt: got %0d want 1", ckptCnt);
    end
    renEn = 1'b1; renName = 5'd7; renTag = 4'd5;
    step();
    idle();
    expect_rd(5'd7, 4'd5, 32'h0);
    check_rd("spec_rename");
    misTaken = 1'b1;
    step();
    idle();
    expect_rd(5'd7, 4'd2, 32'h0);
    check_rd("mis_restore");
    checks++;
    if (ckptCnt !== 2'd0) begin
      errors++;
      $display("FAIL mis_cnt: got %0d want 0", ckptCnt);
    end
  endtask

  task automatic test_ckpt_wb;
    renEn = 1'b1; renName = 5'd12; renTag = 4'd9; branchDeeper = 1'b1;
    step();
    idle();
    wbEn = 2'b10; wbTag = {4'h9, 4'h0}; wbData = {32'h55, 32'h0};
    step();
    idle();
    misTaken = 1'b1;
    step();
    idle();
    expect_rd(5'd12, 4'hF, 32'h55);
    check_rd("wb_all_slots");
    renEn = 1'b1; renName = 5'd13; renTag = 4'd10; branchDeeper = 1'b1;
    step();
    idle();
    misTaken = 1'b1; wbEn = 2'b01; wbTag = {4'h0, 4'hA}; wbData = {32'h0, 32'h66};
    renEn = 1'b1; renName = 5'd14; renTag = 4'd11; branchDeeper = 1'b1; bFreeEn = 1'b1;
    step();
    idle();
    expect_rd(5'd13, 4'hF, 32'h66);
    expect_rd(5'd14, 4'hF, 32'h0);
    check_rd("mis_priority");
    checks++;
    if ({ckptCnt, ovfErr} !== 3'b000) begin
      errors++;
      $display("FAIL mis_priority_cnt: got cnt %0d ovf %b want 0 0", ckptCnt, ovfErr);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 3; i++) begin
      branchDeeper = 1'b1;
      step();
    end
    idle();
    checks++;
    if ({ckptCnt, ckptFull, ovfErr} !== 4'b1110) begin
      errors++;
      $display("FAIL full: got cnt %0d full %b ovf %b want 3 1 0", ckptCnt, ckptFull, ovfErr);
    end
    branchDeeper = 1'b1;
    step();
    idle();
    checks++;
    if ({ckptCnt, ckptFull, ovfErr} !== 4'b1111) begin
      errors++;
      $display("FAIL overflow: got cnt %0d full %b ovf %b want 3 1 1", ckptCnt, ckptFull, ovfErr);
    end
    misTaken = 1'b1;
    step();
    idle();
    checks++;
    if ({ckptCnt, ckptFull, ovfErr} !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_sticky: got cnt %0d full %b ovf %b want 0 0 1", ckptCnt, ckptFull, ovfErr);
    end
  endtask

  task automatic test_wb_priority;
    renEn = 1'b1; renName = 5'd9; renTag = 4'd4;
    step();
    renName = 5'd10;
    step();
    idle();
    wbEn = 2'b11; wbTag = {4'h4, 4'h4}; wbData = {32'h22, 32'h11};
    expect_rd(5'd9, 4'hF, 32'h11);
    expect_rd(5'd10, 4'hF, 32'h11);
    check_rd("dual_wb_fwd");
    step();
    idle();
    expect_rd(5'd9, 4'hF, 32'h11);
    expect_rd(5'd10, 4'hF, 32'h11);
    check_rd("dual_wb_hold");
    renEn = 1'b1; renName = 5'd11; renTag = 4'd6;
    step();
    idle();
    wbEn = 2'b11; wbTag = {4'h6, 4'h7}; wbData = {32'h33, 32'h44};
    step();
    idle();
    expect_rd(5'd11, 4'hF, 32'h33);
    check_rd("port1_wb");
    renEn = 1'b1; renName = 5'd0; renTag = 4'd6;
    step();
    idle();
    expect_rd(5'd0, 4'hF, 32'h0);
    check_rd("x0_rename");
  endtask

  task automatic test_free;
    branchDeeper = 1'b1;
    step();
    step();
    idle();
    checks++;
    if (ckptCnt !== 2'd2) begin
      errors++;
      $display("FAIL two_deep: got %0d want 2", ckptCnt);
    end
    bFreeEn = 1'b1; misTaken = 1'b1;
    step();
    idle();
    checks++;
    if (ckptCnt !== 2'd0) begin
      errors++;
      $display("FAIL free_mis: got %0d want 0", ckptCnt);
    end
    branchDeeper = 1'b1;
    step();
    step();
    idle();
    bFreeEn = 1'b1;
    step();
    idle();
    checks++;
    if (ckptCnt !== 2'd1) begin
      errors++;
      $display("FAIL free_one: got %0d want 1", ckptCnt);
    end
    bFreeEn = 1'b1; branchDeeper = 1'b1;
    step();
    idle();
    checks++;
    if (ckptCnt !== 2'd1) begin
      errors++;
      $display("FAIL free_and_deeper: got %0d want 1", ckptCnt);
    end
    bFreeEn = 1'b1;
    step();
    step();
    idle();
    checks++;
    if ({ckptCnt, ckptFull} !== 3'b000) begin
      errors++;
      $display("FAIL free_at_zero: got cnt %0d full %b want 0 0", ckptCnt, ckptFull);
    end
  endtask

  task automatic test_reset_mid;
    renEn = 1'b1; renName = 5'd3; renTag = 4'd8;
    step();
    idle();
    branchDeeper = 1'b1;
    step();
    step();
    idle();
    expect_rd(5'd3, 4'd8, 32'h0);
    check_rd("pre_reset_x3");
    branchDeeper = 1'b1; renEn = 1'b1; renName = 5'd3; renTag = 4'd1; rst = 1'b0;
    step();
    idle();
    rst = 1'b1;
    checks++;
    if ({ckptCnt, ckptFull, ovfErr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got cnt %0d full %b ovf %b want 0 0 0", ckptCnt, ckptFull, ovfErr);
    end
    expect_rd(5'd3, 4'hF, 32'h0);
    expect_rd(5'd9, 4'hF, 32'h0);
    check_rd("reset_mid_read");
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rdName = '0; wbTag = '0; wbData = '0; renName = '0; renTag = '0;
    test_reset();
    test_wb_forward();
    test_branch_restore();
    test_ckpt_wb();
    test_overflow();
    test_wb_priority();
    test_free();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rename_ckpt_file.md
RENAME_CKPT_FILE -- requirements
Module: rename_ckpt_file

Interface
REQ-001 SHALL expose parameter NREG, default 32: architectural register count; register 0 is hardwired zero.
REQ-002 SHALL expose parameter NAME_W, default 5: register name width, log2(NREG).
REQ-003 SHALL expose parameter DATA_W, default 32: data width.
REQ-004 SHALL expose parameter TAG_W, default 4: rename tag width.
REQ-005 SHALL expose parameter TAG_FREE, default all ones: tag value meaning "value ready, not renamed".
REQ-006 SHALL expose parameter DEPTH, default 4: branch checkpoints per register, power of 2, 2 or more; CK_W = log2(DEPTH).
REQ-007 SHALL expose parameter NWB, default 2: writeback broadcast ports.
REQ-008 SHALL expose parameter NRD, default 2: read ports.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-011 wbEn  in  NWB  per-port writeback valid.
REQ-012 wbTag  in  NWB*TAG_W  per-port writeback tag, port k at bits [k*TAG_W +: TAG_W].
REQ-013 wbData  in  NWB*DATA_W  per-port writeback data, packed the same way.
REQ-014 rdName  in  NRD*NAME_W  read names, packed.
REQ-015 rdData  out  NRD*DATA_W  read data, packed.
REQ-016 rdTag  out  NRD*TAG_W  read tags, packed.
REQ-017 renEn  in  1  rename enable.
REQ-018 renName  in  NAME_W  register being renamed.
REQ-019 renTag  in  TAG_W  new tag for that register.
REQ-020 branchDeeper  in  1  push a new checkpoint.
REQ-021 bFreeEn  in  1  oldest unresolved branch resolved correctly.
REQ-022 misTaken  in  1  oldest unresolved branch mispredicted.
REQ-023 ckptCnt  out  CK_W  live speculative checkpoints, (tail-head) mod DEPTH.
REQ-024 ckptFull  out  1  high when ckptCnt == DEPTH-1.
REQ-025 ovfErr  out  1  sticky flag: branchDeeper arrived while ckptFull was high.

Function
REQ-026 Each register SHALL hold DEPTH (tag,data) slots as a circular buffer, with head/tail pointers (CK_W bits, wrapping DEPTH-1 -> 0) shared by all registers.
REQ-027 Writeback: every slot of every register whose tag equals wbTag[k], with wbEn[k] high and the tag not TAG_FREE, SHALL load wbData[k] and tag TAG_FREE at the next edge; if several ports match, the lowest k wins.
REQ-028 Read: rdData/rdTag[p] SHALL be combinational from the tail slot of rdName[p], with the same-cycle writeback applied (forwarded); rdName[p]==0 returns data 0, tag TAG_FREE.
REQ-029 Rename: with renEn and renName!=0, the tail slot tag of renName SHALL become renTag at the next edge, overriding any same-cycle writeback match on that slot; data is unchanged. renName==0 is ignored.
REQ-030 branchDeeper with ckptFull low and misTaken low SHALL set tail to tail+1 and copy every register's post-writeback tail slot into slot tail+1, with the same-cycle rename applied to both slots.
REQ-031 branchDeeper with ckptFull high SHALL be ignored and set ovfErr.
REQ-032 bFreeEn with misTaken low and ckptCnt>0 SHALL set head to head+1; bFreeEn at ckptCnt==0 is ignored.
REQ-033 misTaken SHALL set tail to head and has priority: same-cycle bFreeEn, branchDeeper and renEn are ignored, while writebacks still apply to all slots.
REQ-034 bFreeEn together with branchDeeper (no misTaken) SHALL perform both; ckptCnt is unchanged and ckptFull is not re-checked against the post-free count.
REQ-035 Outputs ckptCnt and ckptFull SHALL be combinational from the registered head/tail.

Reset
REQ-036 With rst low at an edge: all slots get tag TAG_FREE and data 0; head=tail=0; ovfErr=0; so ckptCnt=0, ckptFull=0, and every read returns 0/TAG_FREE.
REQ-037 Reset SHALL take precedence over every other input in the same cycle, including mid-speculation (ckptCnt>0).

Verification
REQ-038 Rename x5 to tag 3, then wbEn[0]=1, wbTag=3, wbData=0xAB -> the read shows tag 3 until the edge, the same-cycle read shows 0xAB/TAG_FREE, and after the edge the read holds it.
REQ-039 Rename x7 to tag 2 with branchDeeper in the same cycle, then rename x7 to tag 5, then misTaken -> x7 reads tag 2, ckptCnt=0.
REQ-040 With DEPTH=4, issue 3 branchDeeper -> ckptFull=1; a 4th -> ignored, ovfErr=1, ckptCnt=3.
REQ-041 Ports 0 and 1 both write tag 4 with 0x11 and 0x22 -> the matching slots take 0x11; rename on x0 -> x0 still reads 0.
REQ-042 Same-cycle bFreeEn and misTaken at ckptCnt=2 -> head unchanged, tail=head, ckptCnt=0.
REQ-043 Drive rst low at ckptCnt=2 with x3 renamed -> next cycle ckptCnt=0, x3 reads 0/TAG_FREE, ovfErr=0.
